// File: rtl/hazard_mult_ctrl.sv
// hazard_mult_ctrl: ID-stage hazard and sequencing controller for the
// 5-stage MIPS-Lite core. It resolves load-use stalls, branch/jump flushes
// and sequences the multi-cycle MULTU unit, including the HI/LO write strobe.
// Only the FSM state and the cycle counter are registered; every output is
// combinational from state/cnt, the ID/EX inputs and rst_n.
module hazard_mult_ctrl #(
    parameter int MULT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       id_is_multu,
    input  logic       id_reads_hilo,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       mult_start,
    output logic       mult_busy,
    output logic       hilo_we
);

    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic load_use;
    logic hilo_stall;
    logic start_ok;
    logic cnt_done;

    // Hazard terms; register 0 is hardwired so a load to it never interlocks.
    always_comb begin
        load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rt)) ||
                      (id_uses_rt && (id_rt == ex_rt)));
        hilo_stall = (state == MULT) && (id_is_multu || id_reads_hilo);
        start_ok   = (state == IDLE) && id_is_multu && !ex_branch_taken && !load_use;
        cnt_done   = (cnt == '0);
    end

    // State register: reset aborts any running multiply without a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: load the counter on acceptance, count down while running.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = MULT;
                    cnt_next   = CNT_LOAD;
                end
            end
            MULT: begin
                if (cnt_done) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: reset overrides all, then branch flush > stall > jump flush.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mult_start   = 1'b0;
        mult_busy    = 1'b0;
        hilo_we      = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use || hilo_stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (id_jump) begin
                if_id_flush  = 1'b1;
            end
            mult_start = start_ok;
            mult_busy  = (state == MULT);
            hilo_we    = (state == MULT) && cnt_done;
        end
    end

endmodule
